// File: rtl/regfile_dump_reader.sv
// Debug read-out engine for the SEQ register file.
// On a start pulse it walks r0..r(NUM_REGS-1) through the read port, streams each
// value over a valid/ready channel, then sends one trailer beat carrying the
// wrapping 64-bit sum of all dumped values. cpu_hold stays high for the whole dump.
module regfile_dump_reader #(
    parameter int NUM_REGS = 15,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              cpu_hold,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    // Trailer index is all-ones (RNONE), which no data beat can carry.
    localparam logic [ADDR_W-1:0] TRAIL_ADDR = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [DATA_W-1:0] sum_q,   sum_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;
    logic              xfer;

    // A beat moves only when it is actually presented and the sink accepts it.
    assign xfer = valid_q & out_ready;

    // Next-state logic for the dump sequencer and the output beat registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Register value is captured here; the checksum wraps silently.
                data_d  = rf_data;
                addr_d  = idx_q;
                valid_d = 1'b1;
                sum_d   = sum_q + rf_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        data_d  = sum_q;
                        addr_d  = TRAIL_ADDR;
                        last_d  = 1'b1;
                        state_d = S_TRAIL;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_TRAIL: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and beat registers; reset abandons any dump in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Read port is only steered to a register during its own FETCH cycle.
    assign rf_addr   = (state_q == S_FETCH) ? idx_q : '0;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign cpu_hold  = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader. The expected beat list for a dump
// is derived directly from the register-file contents: one beat per register in
// index order, then a trailer holding their wrapping sum.
module tb_regfile_dump_reader;
    localparam int NUM_REGS = 15;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              out_ready;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              cpu_hold;
    logic              done;

    logic [DATA_W-1:0] rf [0:15];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    regfile_dump_reader #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_last (out_last),
        .cpu_hold (cpu_hold),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_addr"},  64'(out_addr),  64'd0);
        chk({nm, "_data"},  out_data,       64'd0);
        chk({nm, "_last"},  64'(out_last),  64'd0);
        chk({nm, "_rfaddr"}, 64'(rf_addr),  64'd0);
        chk({nm, "_hold"},  64'(cpu_hold),  64'd0);
        chk({nm, "_done"},  64'(done),      64'd0);
    endtask

    task automatic clear_rf();
        for (int i = 0; i < 16; i++) rf[i] = '0;
    endtask

    task automatic random_rf();
        for (int i = 0; i < NUM_REGS; i++) rf[i] = {$urandom, $urandom};
        rf[15] = '0;
    endtask

    // mode 0: sink always ready; 1: random ready; 2: 3-cycle stall on addr 7;
    // 3: extra start pulse during SEND of addr 3; 4: reset during SEND of addr 9.
    task automatic dump(input int mode, input string nm);
        logic [63:0] exp_d [0:15];
        logic [3:0]  exp_a [0:15];
        logic        exp_l [0:15];
        logic [63:0] sum;
        logic        pv, pr;
        logic [3:0]  pa;
        logic [63:0] pd;
        int beat, cyc, seen7, stalls, dones;
        bit aborted;
        sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_a[i] = 4'(i);
            exp_d[i] = rf[i];
            exp_l[i] = 1'b0;
            sum      = sum + rf[i];
        end
        exp_a[NUM_REGS] = 4'hF;
        exp_d[NUM_REGS] = sum;
        exp_l[NUM_REGS] = 1'b1;

        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_fetch_hold"},  64'(cpu_hold),  64'd1);
        chk({nm, "_fetch_valid"}, 64'(out_valid), 64'd0);

        beat = 0; cyc = 0; seen7 = 0; stalls = 0; dones = 0;
        pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
        aborted = 1'b0;
        while (beat <= NUM_REGS && cyc < 2000 && !aborted) begin
            if (pv && !pr) begin
                chk({nm, "_held_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_held_addr"},  64'(out_addr),  64'(pa));
                chk({nm, "_held_data"},  out_data,       pd);
            end
            chk({nm, "_hold"}, 64'(cpu_hold), 64'd1);
            if (done) dones++;
            if (out_valid) begin
                chk({nm, "_beat_addr"}, 64'(out_addr), 64'(exp_a[beat]));
                chk({nm, "_beat_data"}, out_data,      exp_d[beat]);
                chk({nm, "_beat_last"}, 64'(out_last), 64'(exp_l[beat]));
                if (out_addr == 4'd7) seen7++;
            end
            out_ready = 1'b1;
            start = 1'b0;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: if (out_valid && out_addr == 4'd7 && stalls < 3) begin
                       out_ready = 1'b0;
                       stalls++;
                   end
                3: if (out_valid && out_addr == 4'd3) start = 1'b1;
                4: if (out_valid && out_addr == 4'd9) begin
                       rst = 1'b1;
                       aborted = 1'b1;
                   end
                default: ;
            endcase
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
            if (out_valid && out_ready) beat++;
            @(negedge clk);
            cyc++;
        end

        if (aborted) begin
            rst = 1'b0;
            chk_idle_outputs({nm, "_abort"});
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk({nm, "_abort_done"}, 64'(done),     64'd0);
                chk({nm, "_abort_hold"}, 64'(cpu_hold), 64'd0);
            end
        end else begin
            chk({nm, "_beats"}, 64'(beat), 64'(NUM_REGS + 1));
            chk({nm, "_early_done"}, 64'(dones), 64'd0);
            chk({nm, "_fin_done"},  64'(done),      64'd1);
            chk({nm, "_fin_hold"},  64'(cpu_hold),  64'd1);
            chk({nm, "_fin_valid"}, 64'(out_valid), 64'd0);
            chk({nm, "_fin_last"},  64'(out_last),  64'd0);
            if (mode == 0) chk({nm, "_cycles"}, 64'(cyc), 64'(2 * NUM_REGS + 1));
            if (mode == 2) chk({nm, "_stall7"}, 64'(seen7), 64'd4);
            @(negedge clk);
            chk({nm, "_post_done"}, 64'(done),     64'd0);
            chk({nm, "_post_hold"}, 64'(cpu_hold), 64'd0);
            if (mode == 3) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk({nm, "_noqueue_hold"}, 64'(cpu_hold), 64'd0);
                    chk({nm, "_noqueue_done"}, 64'(done),     64'd0);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        clear_rf();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Post-reset file with only r4 set.
        clear_rf();
        rf[4] = 64'd50;
        dump(0, "t1");

        // r_i = i+1.
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 64'(i + 1);
        dump(0, "t2");

        // Backpressure on the r7 beat.
        random_rf();
        rf[7] = 64'hDEAD;
        dump(2, "t3");

        // Checksum wrap.
        clear_rf();
        rf[0] = '1;
        rf[1] = '1;
        dump(1, "t4");

        // Stray start while a dump is running.
        random_rf();
        dump(3, "t5");

        // Reset mid-dump, then a fresh dump.
        random_rf();
        dump(4, "t6");
        random_rf();
        dump(0, "t6b");

        // start and rst in the same cycle.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_hold",  64'(cpu_hold),  64'd0);
        chk("rst_start_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("rst_start_hold2", 64'(cpu_hold), 64'd0);

        // Random contents under random backpressure.
        for (int r = 0; r < 4; r++) begin
            random_rf();
            dump(1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
